// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store port between the core memory stage and the
//               dmem_responder.
//               Request channel:  req_valid, req_ready, req_we, req_funct3,
//                                 req_addr, req_wdata
//               Response channel: rsp_valid, rsp_ready, rsp_rdata
//                                 (+ rsp_err when MISALIGN_ERR_EN is defined)
//               master modport = core side, slave modport = memory side.
// Options     : `define MISALIGN_ERR_EN adds the rsp_err response signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
`ifdef MISALIGN_ERR_EN
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the core load/store port. Accepts
//               one request per valid/ready handshake, performs a byte/half/
//               word access on an internal word array after WAIT_CYCLES wait
//               states and returns the result on a valid/ready response.
// Ports       : clk    - clock, all state changes on rising edge
//               reset  - synchronous, active-high
//               bus    - dmem_responder_if.slave (request + response channels)
// Parameters  : DEPTH_WORDS - number of 32-bit words (address wraps)
//               WAIT_CYCLES - wait states between accept and response (0..15)
// Options     : `define MISALIGN_ERR_EN - flag misaligned/illegal accesses on
//               rsp_err instead of forcing alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_responder_if.slave  bus
);

    localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    // With zero wait states the access happens on the accept edge itself, so
    // the access path selects the live request in IDLE and the latched one
    // otherwise.
    logic              w_idle;
    logic              w_sel_we;
    logic [2:0]        w_sel_f3;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic              w_is_byte;
    logic              w_is_half;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wrep;
    logic [31:0]       w_merged;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic              w_err;
    logic [31:0]       w_rsp_data;
    logic              w_do_access;
    logic              w_mem_we;
    logic              w_unused;

    assign w_idle      = (r_state == c_IDLE);
    assign w_sel_we    = w_idle ? bus.req_we     : r_we;
    assign w_sel_f3    = w_idle ? bus.req_funct3 : r_funct3;
    assign w_sel_addr  = w_idle ? bus.req_addr   : r_addr;
    assign w_sel_wdata = w_idle ? bus.req_wdata  : r_wdata;

    assign w_idx  = w_sel_addr[c_IDX_W+1:2];
    assign w_word = r_mem[w_idx];

    // funct3[1:0] encodes size: 00 byte, 01 half, 1x word (illegal codes
    // fall into the word case).
    assign w_is_byte = (w_sel_f3[1:0] == 2'b00);
    assign w_is_half = (w_sel_f3[1:0] == 2'b01);
    assign w_lane    = w_is_byte ? w_sel_addr[1:0] :
                       w_is_half ? {w_sel_addr[1], 1'b0} : 2'b00;

    always_comb begin
        w_be   = 4'b1111;
        w_wrep = w_sel_wdata;
        if (w_is_byte) begin
            w_be   = 4'b0001 << w_lane;
            w_wrep = {4{w_sel_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wrep = {2{w_sel_wdata[15:0]}};
        end
    end

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_wrep[8*i +: 8];
            end
        end
    end

    assign w_shifted = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = w_shifted;
        if (w_is_byte) begin
            w_load = w_sel_f3[2] ? {24'd0, w_shifted[7:0]}
                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            w_load = w_sel_f3[2] ? {16'd0, w_shifted[15:0]}
                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
    end

`ifdef MISALIGN_ERR_EN
    always_comb begin
        w_err = 1'b0;
        case (w_sel_f3)
            3'b000, 3'b100: w_err = 1'b0;
            3'b001, 3'b101: w_err = w_sel_addr[0];
            3'b010:         w_err = (w_sel_addr[1:0] != 2'b00);
            default:        w_err = 1'b1;
        endcase
        if (w_sel_we && w_sel_f3[2]) begin
            w_err = 1'b1;
        end
    end
`else
    assign w_err = 1'b0;
`endif

    assign w_rsp_data = (w_err || w_sel_we) ? 32'd0 : w_load;

    // Reset suppresses the write, so a store still waiting in BUSY is dropped.
    assign w_do_access = !reset &&
                         ((w_idle && bus.req_valid && (WAIT_CYCLES == 0)) ||
                          ((r_state == c_BUSY) && (r_cnt == 4'd1)));
    assign w_mem_we    = w_do_access && w_sel_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_rdata <= w_rsp_data;
                            r_err   <= w_err;
                            r_state <= c_RESP;
                        end else begin
                            r_cnt   <= c_WAIT;
                            r_state <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rdata <= w_rsp_data;
                        r_err   <= w_err;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_idle && !reset;
    assign bus.rsp_valid = (r_state == c_RESP) && !reset;
    assign bus.rsp_rdata = r_rdata;
`ifdef MISALIGN_ERR_EN
    assign bus.rsp_err   = r_err;
    assign w_unused      = ^{w_sel_addr[31:c_IDX_W+2]};
`else
    assign w_unused      = ^{w_sel_addr[31:c_IDX_W+2], r_err};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A transaction-level
//               memory model (byte-lane arithmetic on an associative array)
//               predicts every response; a compare process checks handshake
//               and data outputs each cycle. Directed literal checks pin the
//               model, then randomized traffic runs against it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;
    parameter int WAIT = 1;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // ---------------- behavioural model ----------------
    logic [31:0] mm [int];
    bit          m_pending = 1'b0;
    bit          m_done    = 1'b0;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wd, m_rd;
    logic        m_err;
    int          edge_n = 0;
    int          m_due  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int w;
        int size;
        int b;
        logic [31:0] word, mask, v;
        w    = int'(a >> 2) % DEPTH;
        word = mm.exists(w) ? mm[w] : 32'd0;
        er   = 1'b0;
`ifdef MISALIGN_ERR_EN
        if (f3 == 3'd1 || f3 == 3'd5) er = a[0];
        else if (f3 == 3'd2) er = (a[1:0] != 2'd0);
        else if (f3 != 3'd0 && f3 != 3'd4) er = 1'b1;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) er = 1'b1;
`endif
        if (f3 == 3'd0 || f3 == 3'd4) size = 1;
        else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
        else size = 4;
        b = (size == 1) ? int'(a[1:0]) : (size == 2) ? 2 * int'(a[1]) : 0;
        rd = 32'd0;
        if (er) begin
            rd = 32'd0;
        end else if (we) begin
            mask  = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << (8 * b));
            mm[w] = (word & ~mask) | ((wd << (8 * b)) & mask);
        end else begin
            v = word >> (8 * b);
            if (size == 1) rd = (f3 == 3'd4) ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (size == 2) rd = (f3 == 3'd5) ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else rd = word;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_pending = 1'b0;
                m_done    = 1'b0;
            end else if (m_pending && m_done) begin
                if (bus.rsp_ready) begin
                    m_pending = 1'b0;
                    m_done    = 1'b0;
                end
            end else if (m_pending) begin
                if (edge_n == m_due) begin
                    model_op(m_we, m_f3, m_addr, m_wd, m_rd, m_err);
                    m_done = 1'b1;
                end
            end else if (bus.req_valid) begin
                m_we      = bus.req_we;
                m_f3      = bus.req_funct3;
                m_addr    = bus.req_addr;
                m_wd      = bus.req_wdata;
                m_pending = 1'b1;
                m_due     = edge_n + WAIT;
                if (WAIT == 0) begin
                    model_op(m_we, m_f3, m_addr, m_wd, m_rd, m_err);
                    m_done = 1'b1;
                end
            end
            edge_n++;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !m_pending && !reset});
                chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_pending && m_done && !reset});
                if (reset) begin
                    chk("rdata_in_reset", bus.rsp_rdata, 32'd0);
                end else if (m_pending && m_done) begin
                    chk("rsp_rdata", bus.rsp_rdata, m_rd);
`ifdef MISALIGN_ERR_EN
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_err});
`endif
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input bit keep,
                       output logic [31:0] rd, output logic er);
        int n;
        rd = 32'd0;
        er = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.rsp_ready  = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (keep) begin
            bus.req_we     = 1'($urandom);
            bus.req_funct3 = 3'($urandom);
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
        n = 1;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(WAIT + 1));
        if (!bus.rsp_valid) begin
            bus.req_valid = 1'b0;
            return;
        end
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        rd = bus.rsp_rdata;
`ifdef MISALIGN_ERR_EN
        er = bus.rsp_err;
`endif
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        started = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // directed, literal expectations
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er); chk("sw_ack",  rd, 32'h0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);        chk("lw_10",   rd, 32'hDEADBEEF);
        txn(1'b1, 3'b000, 32'h11, 32'hAA, 0, 1'b0, rd, er);       chk("sb_ack",  rd, 32'h0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);        chk("lw_sb",   rd, 32'hDEADAAEF);
        txn(1'b0, 3'b000, 32'h11, 32'h0, 0, 1'b0, rd, er);        chk("lb_11",   rd, 32'hFFFFFFAA);
        txn(1'b0, 3'b100, 32'h11, 32'h0, 0, 1'b0, rd, er);        chk("lbu_11",  rd, 32'h000000AA);
        txn(1'b1, 3'b010, 32'h20, 32'h12345678, 0, 1'b0, rd, er);
        txn(1'b1, 3'b001, 32'h22, 32'h8001, 0, 1'b0, rd, er);     chk("sh_ack",  rd, 32'h0);
        txn(1'b0, 3'b001, 32'h22, 32'h0, 0, 1'b0, rd, er);        chk("lh_22",   rd, 32'hFFFF8001);
        txn(1'b0, 3'b101, 32'h22, 32'h0, 0, 1'b0, rd, er);        chk("lhu_22",  rd, 32'h00008001);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, rd, er);        chk("lw_20",   rd, 32'h80015678);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b1, rd, er);        chk("lw_hold", rd, 32'hDEADAAEF);
        txn(1'b0, 3'b010, 32'h1010, 32'h0, 0, 1'b0, rd, er);      chk("lw_wrap", rd, 32'hDEADAAEF);
`ifdef MISALIGN_ERR_EN
        txn(1'b0, 3'b010, 32'h13, 32'h0, 0, 1'b0, rd, er);
        chk("lw_mis_rdata", rd, 32'h0);
        chk("lw_mis_err", {31'd0, er}, 32'd1);
        txn(1'b1, 3'b001, 32'h21, 32'hFFFF, 0, 1'b0, rd, er);
        chk("sh_mis_err", {31'd0, er}, 32'd1);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, rd, er);
        chk("lw_20_kept", rd, 32'h80015678);
`else
        txn(1'b0, 3'b010, 32'h13, 32'h0, 0, 1'b0, rd, er);        chk("lw_13_align", rd, 32'hDEADAAEF);
`endif

        // reset while a store is outstanding
        txn(1'b1, 3'b010, 32'h30, 32'h11111111, 0, 1'b0, rd, er);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        txn(1'b0, 3'b010, 32'h30, 32'h0, 0, 1'b0, rd, er);
        chk("lw_after_reset", rd, (WAIT > 0) ? 32'h11111111 : 32'hCAFEF00D);

        // seed the random region, then random traffic
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 3'b010, 32'(4 * i), $urandom, 0, 1'b0, rd, er);
        end
        for (int i = 0; i < 250; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom);
`ifdef MISALIGN_ERR_EN
            f3 = 3'($urandom);
`else
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom);
`endif
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            txn(we, f3, a, $urandom, int'($urandom_range(0, 2)), 1'($urandom), rd, er);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one request per valid/ready handshake, performs a byte/half/word access on an internal word array, and returns a response through a valid/ready handshake.
- Latency between accept and response is a fixed, programmable number of wait states.
- Sits between the core's memory stage and data storage. Lets the pipeline be exercised against a memory that does not answer combinationally.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; word index = req_addr[$clog2(DEPTH_WORDS)+1:2]; higher address bits ignored (wraps modulo DEPTH_WORDS*4).
- WAIT_CYCLES, 1: wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response available
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load result, already extended; 0 for store acks

Behaviour:
- Reset:
  - reset, clk: synchronous, active-high reset named reset; clock clk.
  - While reset is high: state = IDLE, rsp_valid = 0, rsp_rdata = 0, wait counter = 0, request latches cleared.
  - req_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
  - Array contents are not cleared.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1: latch we, funct3, addr, wdata.
  - If WAIT_CYCLES = 0: perform the access on that edge and go to RESP.
  - Otherwise: cnt = WAIT_CYCLES and go to BUSY.
- BUSY:
  - req_ready = 0; cnt decrements each edge.
  - On the edge where cnt = 1: perform the access, register rsp_rdata, go to RESP.
- Latency: rsp_valid first rises WAIT_CYCLES+1 cycles after the accept cycle.
- RESP:
  - rsp_valid = 1; rsp_rdata held stable until rsp_ready = 1.
  - On an edge with rsp_ready = 1: go to IDLE, rsp_valid = 0.
  - New request cannot be accepted before the cycle after the response handshake. Minimum spacing between accepts: WAIT_CYCLES+2 cycles.
- Stores: read-modify-write of the addressed word.
  - SB writes byte addr[1:0] from wdata[7:0].
  - SH writes half addr[1] from wdata[15:0].
  - SW writes the full word.
  - Other bytes are unchanged. rsp_rdata = 0.
- Loads: extract byte/half by addr[1:0]/addr[1].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Ordering: a load issued after a store completes returns the stored data.
- Request inputs are sampled only at the accept edge; changes while BUSY or RESP have no effect.
- Reset mid-operation:
  - Store still in BUSY: not written.
  - Store already in RESP: written.
  - Pending response: discarded.

Optional Feature:
- Macro: MISALIGN_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit), reset 0, valid with rsp_valid.
  - Error cases: H/HU with addr[0] = 1; W with addr[1:0] != 0; funct3 outside {000,001,010,100,101}; store with funct3 100/101.
  - On an error: no array write, rsp_rdata = 0, rsp_err = 1; latency unchanged.
- Undefined:
  - No rsp_err port.
  - Low address bits are forced to alignment (addr[0] ignored for H, addr[1:0] ignored for W).
  - Illegal funct3 is treated as W.

Test Plan:
- Reset, then SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 (WAIT_CYCLES = 1) -> store ack rsp_rdata = 0 two cycles after accept; load returns 0xDEADBEEF.
- After the previous step, SB addr 0x11 wdata 0x000000AA, then LW 0x10 -> 0xDEADAAEF; LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
- SH addr 0x22 wdata 0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> upper half 0x8001, lower half unchanged.
- Hold rsp_ready = 0 for 5 cycles in RESP with req_valid = 1 continuously -> rsp_valid and rsp_rdata stable, req_ready = 0, exactly one access performed; release -> IDLE next cycle.
- WAIT_CYCLES = 0 and WAIT_CYCLES = 3 builds -> rsp_valid 1 and 4 cycles after accept; reset asserted while BUSY with a store -> location unchanged, rsp_valid = 0.
- MISALIGN_ERR_EN: LW addr 0x13 -> rsp_err = 1, rsp_rdata = 0; SH 0x21 -> rsp_err = 1 and word 0x20 unchanged. Without the macro: LW 0x13 returns the word at 0x10.
